// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with rename-tag dependency tracking
//
// Ports:
//   clk_in, rst_in, rdy_in        clock, synchronous active-high reset, global enable
//   dec_*                         issuing instruction: sources, destination, ROB slot
//   rob2rf_ready, rob_rd,
//   rob_value, rob_dependency     ROB commit write-back
//   need_flush                    misprediction flush, drops all pending tags
//   rf_dependency1/2              tags presented to the ROB for result lookup
//   rob_found1/2, rob_value1/2    ROB lookup answers
//   op1_*/op2_*                   resolved operands (ready, value, producer tag)

module reg_file #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5,
    parameter logic [ROB_SIZE_WIDTH:0] DEP_NONE = '1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,

    input  logic                      dec_valid,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rs1,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rs2,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_rob_id,

    input  logic                      rob2rf_ready,
    input  logic [REG_NUM_WIDTH-1:0]  rob_rd,
    input  logic [31:0]               rob_value,
    input  logic [ROB_SIZE_WIDTH:0]   rob_dependency,

    input  logic                      need_flush,

    output logic [ROB_SIZE_WIDTH:0]   rf_dependency1,
    output logic [ROB_SIZE_WIDTH:0]   rf_dependency2,
    input  logic                      rob_found1,
    input  logic                      rob_found2,
    input  logic [31:0]               rob_value1,
    input  logic [31:0]               rob_value2,

    output logic                      op1_ready,
    output logic                      op2_ready,
    output logic [31:0]               op1_value,
    output logic [31:0]               op2_value,
    output logic [ROB_SIZE_WIDTH:0]   op1_dep,
    output logic [ROB_SIZE_WIDTH:0]   op2_dep
);

    localparam int NREG = 2 ** REG_NUM_WIDTH;

    typedef struct packed {
        logic                    ready;
        logic [31:0]             value;
        logic [ROB_SIZE_WIDTH:0] dep;
    } operand_t;

    logic [31:0]             value_q [NREG];
    logic [ROB_SIZE_WIDTH:0] dep_q   [NREG];

    logic [ROB_SIZE_WIDTH:0] dep_rs1, dep_rs2;
    logic [31:0]             val_rs1, val_rs2;
    operand_t                opnd1, opnd2;

    // First match wins: x0, no pending producer, same-cycle commit bypass,
    // ROB already holding the result, otherwise wait on the producer tag.
    function automatic operand_t resolve(
        input logic [REG_NUM_WIDTH-1:0]  rs,
        input logic [ROB_SIZE_WIDTH:0]   rs_dep,
        input logic [31:0]               rs_val,
        input logic                      found,
        input logic [31:0]               found_val,
        input logic                      cm_valid,
        input logic [REG_NUM_WIDTH-1:0]  cm_rd,
        input logic [ROB_SIZE_WIDTH:0]   cm_dep,
        input logic [31:0]               cm_val
    );
        operand_t r;
        r.ready = 1'b1;
        r.value = '0;
        r.dep   = DEP_NONE;
        if (rs == '0) begin
            r.value = '0;
        end else if (rs_dep == DEP_NONE) begin
            r.value = rs_val;
        end else if (cm_valid && cm_rd == rs && cm_dep == rs_dep) begin
            r.value = cm_val;
        end else if (found) begin
            r.value = found_val;
        end else begin
            r.ready = 1'b0;
            r.dep   = rs_dep;
        end
        return r;
    endfunction

    // Reads always see pre-edge state, so an instruction whose source equals
    // its own destination resolves against the older tag.
    always_comb begin
        dep_rs1 = dep_q[dec_rs1];
        dep_rs2 = dep_q[dec_rs2];
        val_rs1 = value_q[dec_rs1];
        val_rs2 = value_q[dec_rs2];

        rf_dependency1 = (dec_rs1 == '0) ? DEP_NONE : dep_rs1;
        rf_dependency2 = (dec_rs2 == '0) ? DEP_NONE : dep_rs2;

        opnd1 = resolve(dec_rs1, dep_rs1, val_rs1, rob_found1, rob_value1,
                        rob2rf_ready, rob_rd, rob_dependency, rob_value);
        opnd2 = resolve(dec_rs2, dep_rs2, val_rs2, rob_found2, rob_value2,
                        rob2rf_ready, rob_rd, rob_dependency, rob_value);

        op1_ready = opnd1.ready;
        op1_value = opnd1.value;
        op1_dep   = opnd1.dep;
        op2_ready = opnd2.ready;
        op2_value = opnd2.value;
        op2_dep   = opnd2.dep;
    end

    // Commit is applied first so a same-cycle issue to the same register
    // overrides the cleared tag. A flush still lets the commit write its
    // value because the ROB retires a JALR together with its flush.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                dep_q[i]   <= DEP_NONE;
            end
        end else if (rdy_in) begin
            if (rob2rf_ready && rob_rd != '0) begin
                value_q[rob_rd] <= rob_value;
                // A tag mismatch means a younger producer owns the register.
                if (dep_q[rob_rd] == rob_dependency)
                    dep_q[rob_rd] <= DEP_NONE;
            end
            if (need_flush) begin
                for (int i = 0; i < NREG; i++)
                    dep_q[i] <= DEP_NONE;
            end else if (dec_valid && dec_rd != '0) begin
                dep_q[dec_rd] <= {1'b0, dec_rob_id};
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file

module tb_reg_file;

    localparam int N = 63;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, dec_rob_id;
    logic        rob2rf_ready;
    logic [4:0]  rob_rd;
    logic [31:0] rob_value;
    logic [5:0]  rob_dependency;
    logic        need_flush;
    logic [5:0]  rf_dependency1, rf_dependency2;
    logic        rob_found1, rob_found2;
    logic [31:0] rob_value1, rob_value2;
    logic        op1_ready, op2_ready;
    logic [31:0] op1_value, op2_value;
    logic [5:0]  op1_dep, op2_dep;

    always #5 clk_in = ~clk_in;

    reg_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
        .rob2rf_ready(rob2rf_ready), .rob_rd(rob_rd), .rob_value(rob_value),
        .rob_dependency(rob_dependency), .need_flush(need_flush),
        .rf_dependency1(rf_dependency1), .rf_dependency2(rf_dependency2),
        .rob_found1(rob_found1), .rob_found2(rob_found2),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .op1_ready(op1_ready), .op2_ready(op2_ready),
        .op1_value(op1_value), .op2_value(op2_value),
        .op1_dep(op1_dep), .op2_dep(op2_dep)
    );

    typedef struct {
        logic        rst, rdy, dv;
        logic [4:0]  rs1, rs2, rd, rid;
        logic        cv;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic [5:0]  cdep;
        logic        fl, f1, f2;
        logic [31:0] v1, v2;
        logic        r1, r2;
        logic [31:0] o1, o2;
        logic [5:0]  d1, d2, q1, q2;
    } vec_t;

    typedef struct {
        logic        r1, r2;
        logic [31:0] o1, o2;
        logic [5:0]  d1, d2, q1, q2;
    } exp_t;

    vec_t tab[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t st(int rs1, int rs2, int dv, int rd, int rid,
                                int cv, int crd, int unsigned cval, int cdep, int fl);
        vec_t t;
        t.rst = 1'b0; t.rdy = 1'b1;
        t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.dv = 1'(dv); t.rd = 5'(rd); t.rid = 5'(rid);
        t.cv = 1'(cv); t.crd = 5'(crd); t.cval = cval; t.cdep = 6'(cdep);
        t.fl = 1'(fl);
        t.f1 = 1'b0; t.f2 = 1'b0; t.v1 = '0; t.v2 = '0;
        t.r1 = 1'b0; t.r2 = 1'b0; t.o1 = '0; t.o2 = '0;
        t.d1 = '0; t.d2 = '0; t.q1 = '0; t.q2 = '0;
        return t;
    endfunction

    function automatic vec_t rd2(int rs1, int rs2);
        return st(rs1, rs2, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add(input vec_t t, input int r1, input int unsigned o1, input int d1,
                       input int q1, input int r2, input int unsigned o2, input int d2,
                       input int q2);
        vec_t v;
        v = t;
        v.r1 = 1'(r1); v.o1 = o1; v.d1 = 6'(d1); v.q1 = 6'(q1);
        v.r2 = 1'(r2); v.o2 = o2; v.d2 = 6'(d2); v.q2 = 6'(q2);
        tab.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        exp_t e;
        rst_in = t.rst; rdy_in = t.rdy;
        dec_valid = t.dv; dec_rs1 = t.rs1; dec_rs2 = t.rs2;
        dec_rd = t.rd; dec_rob_id = t.rid;
        rob2rf_ready = t.cv; rob_rd = t.crd; rob_value = t.cval; rob_dependency = t.cdep;
        need_flush = t.fl;
        rob_found1 = t.f1; rob_value1 = t.v1; rob_found2 = t.f2; rob_value2 = t.v2;
        e.r1 = t.r1; e.o1 = t.o1; e.d1 = t.d1; e.q1 = t.q1;
        e.r2 = t.r2; e.o2 = t.o2; e.d2 = t.d2; e.q2 = t.q2;
        exp_q.push_back(e);
    endtask

    task automatic sample(input int row);
        exp_t e;
        e = exp_q.pop_front();
        chk("op1_ready", row, 32'(op1_ready), 32'(e.r1));
        chk("op1_value", row, op1_value, e.o1);
        chk("op1_dep",   row, 32'(op1_dep), 32'(e.d1));
        chk("rf_dep1",   row, 32'(rf_dependency1), 32'(e.q1));
        chk("op2_ready", row, 32'(op2_ready), 32'(e.r2));
        chk("op2_value", row, op2_value, e.o2);
        chk("op2_dep",   row, 32'(op2_dep), 32'(e.d2));
        chk("rf_dep2",   row, 32'(rf_dependency2), 32'(e.q2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t t;

        // reset and idle reads
        add(rd2(5, 0),                          1, 0, N, N,   1, 0, N, N);
        // issue x3<-4 reading x3 itself: old tag
        add(st(3, 3, 1, 3, 4, 0, 0, 0, 0, 0),   1, 0, N, N,   1, 0, N, N);
        t = rd2(3, 3); t.f2 = 1; t.v2 = 32'h55;
        add(t,                                  0, 0, 4, 4,   1, 32'h55, N, 4);
        t = st(3, 0, 1, 3, 7, 0, 0, 0, 0, 0); t.f1 = 1; t.v1 = 32'h55;
        add(t,                                  1, 32'h55, N, 4, 1, 0, N, N);
        // stale commit from tag 4: value written, dep stays 7
        add(st(3, 0, 0, 0, 0, 1, 3, 32'h11, 4, 0), 0, 0, 7, 7, 1, 0, N, N);
        add(st(3, 0, 0, 0, 0, 0, 0, 0, 0, 1),   0, 0, 7, 7,   1, 0, N, N);
        add(rd2(3, 8),                          1, 32'h11, N, N, 1, 0, N, N);
        // commit bypass on x8
        add(st(8, 0, 1, 8, 2, 0, 0, 0, 0, 0),   1, 0, N, N,   1, 0, N, N);
        add(st(0, 8, 0, 0, 0, 1, 8, 32'hAB, 2, 0), 1, 0, N, N, 1, 32'hAB, N, 2);
        t = rd2(8, 8); t.f1 = 1; t.v1 = 32'h99;
        add(t,                                  1, 32'hAB, N, N, 1, 32'hAB, N, N);
        // issue and commit to x9 together: issue wins the tag
        add(st(0, 0, 1, 9, 0, 0, 0, 0, 0, 0),   1, 0, N, N,   1, 0, N, N);
        add(st(9, 0, 1, 9, 1, 1, 9, 32'h20, 0, 0), 1, 32'h20, N, 0, 1, 0, N, N);
        t = rd2(9, 9); t.f2 = 1; t.v2 = 32'h77;
        add(t,                                  0, 0, 1, 1,   1, 32'h77, N, 1);
        // flush with commit and issue in the same cycle
        add(st(0, 0, 1, 1, 10, 0, 0, 0, 0, 0),  1, 0, N, N,   1, 0, N, N);
        add(st(0, 0, 1, 2, 11, 0, 0, 0, 0, 0),  1, 0, N, N,   1, 0, N, N);
        add(st(1, 2, 1, 10, 12, 0, 0, 0, 0, 0), 0, 0, 10, 10, 0, 0, 11, 11);
        add(st(1, 10, 1, 4, 13, 1, 1, 32'h1000, 10, 1), 1, 32'h1000, N, 10, 0, 0, 12, 12);
        add(rd2(1, 4),                          1, 32'h1000, N, N, 1, 0, N, N);
        add(rd2(2, 10),                         1, 0, N, N,   1, 0, N, N);
        add(rd2(9, 3),                          1, 32'h20, N, N, 1, 32'h11, N, N);
        // x0 is hardwired
        t = st(0, 0, 1, 0, 5, 1, 0, 32'hDEAD, N, 0); t.f1 = 1; t.v1 = 32'h44;
        add(t,                                  1, 0, N, N,   1, 0, N, N);
        add(rd2(0, 0),                          1, 0, N, N,   1, 0, N, N);
        // rdy_in low holds all state
        t = st(5, 8, 1, 5, 3, 1, 8, 32'h123, N, 0); t.rdy = 0;
        add(t,                                  1, 0, N, N,   1, 32'hAB, N, N);
        add(rd2(5, 8),                          1, 0, N, N,   1, 32'hAB, N, N);
        // reset mid-operation
        add(st(0, 0, 1, 5, 3, 0, 0, 0, 0, 0),   1, 0, N, N,   1, 0, N, N);
        t = rd2(5, 8); t.rst = 1;
        add(t,                                  0, 0, 3, 3,   1, 32'hAB, N, N);
        add(rd2(8, 5),                          1, 0, N, N,   1, 0, N, N);
        add(rd2(3, 1),                          1, 0, N, N,   1, 0, N, N);

        // initial reset held for two edges
        t = rd2(0, 0); t.rst = 1;
        drive(t);
        void'(exp_q.pop_front());
        repeat (2) @(posedge clk_in);

        foreach (tab[i]) begin
            @(negedge clk_in);
            drive(tab[i]);
            #1;
            sample(i);
        end
        @(negedge clk_in);

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
